// File: rtl/trigger_ctrl.sv
// Threshold trigger with pre/post-trigger capture window over an AXI-Stream beat delay line.
// Optional macro TRIGGER_CTRL_RETRIGGER_EN lets hits during TRG extend the capture window.
module trigger_ctrl #(
  parameter int THRESHOLD            = 10,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128,
  parameter int PRE_ACQ_LEN          = 4,
  parameter int POST_ACQ_LEN         = 16
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESET,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BASELINE,
  input  logic                            I_CALC_COMPLETE,
  output logic [1:0]                      EXEC_STATE,
  output logic [S_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST
);

  localparam int AW               = ADC_RESOLUTION_WIDTH;
  localparam int SAMPLE_PER_TDATA = S_AXIS_TDATA_WIDTH / 16;
  localparam int WIN_LEN          = PRE_ACQ_LEN + POST_ACQ_LEN;
  localparam int PCW              = $clog2(POST_ACQ_LEN + 1);
  localparam int OCW              = $clog2(WIN_LEN + 1);
  localparam longint THRESHOLD_VAL = (longint'(THRESHOLD) * (longint'(1) << AW)) / 100;
  // Threshold carries two extra bits so a 100% setting still fits as a positive signed value.
  localparam logic signed [AW+1:0] THR_S    = THRESHOLD_VAL[AW+1:0];
  localparam logic [PCW-1:0]       POST_LOAD = PCW'(POST_ACQ_LEN - 1);
  localparam logic [OCW-1:0]       WIN_LOAD  = OCW'(WIN_LEN);

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_TRG  = 2'b11
  } state_e;

  typedef logic [S_AXIS_TDATA_WIDTH-1:0] beat_t;

  state_e           state_q, state_d;
  logic [PCW-1:0]   post_cnt_q, post_cnt_d;
  logic [OCW-1:0]   out_cnt_q, out_cnt_d;
  beat_t            dl_q [PRE_ACQ_LEN];
  beat_t            dl_d [PRE_ACQ_LEN];
  beat_t            tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;

  logic             hit;
  logic             retrig;
  logic             load;
  logic [OCW-1:0]   win_cnt;
  logic [AW-1:0]    sample;
  logic [AW:0]      diff;

  // Difference is formed one bit wider than a sample so extreme sample/baseline pairs cannot wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit    = 1'b0;
    sample = '0;
    diff   = '0;
    for (int k = 0; k < SAMPLE_PER_TDATA; k++) begin
      sample = S_AXIS_TDATA[16*k +: AW];
      diff   = {sample[AW-1], sample} - {I_BASELINE[AW-1], I_BASELINE};
      if ($signed({diff[AW], diff}) > THR_S) hit = 1'b1;
    end
    hit = hit & S_AXIS_TVALID;
  end

`ifdef TRIGGER_CTRL_RETRIGGER_EN
  assign retrig = hit;
`else
  assign retrig = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    out_cnt_d  = out_cnt_q;
    dl_d       = dl_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    load       = 1'b0;
    win_cnt    = '0;

    case (state_q)
      ST_INIT: if (I_CALC_COMPLETE) state_d = ST_IDLE;
      ST_IDLE: begin
        if (hit) begin
          state_d    = ST_TRG;
          post_cnt_d = POST_LOAD;
          load       = 1'b1;
        end
      end
      ST_TRG: begin
        if (retrig) begin
          post_cnt_d = POST_LOAD;
          load       = 1'b1;
        end else if (S_AXIS_TVALID) begin
          if (post_cnt_q != '0) post_cnt_d = post_cnt_q - PCW'(1);
          else                  state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // The trigger beat itself emits the oldest pre-trigger beat, so a load counts immediately.
    if (S_AXIS_TVALID) begin
      dl_d[0] = S_AXIS_TDATA;
      for (int i = 1; i < PRE_ACQ_LEN; i++) dl_d[i] = dl_q[i-1];
      tdata_d = dl_q[PRE_ACQ_LEN-1];
      win_cnt = load ? WIN_LOAD : out_cnt_q;
      if (win_cnt != '0) begin
        tvalid_d  = 1'b1;
        tlast_d   = (win_cnt == OCW'(1));
        out_cnt_d = win_cnt - OCW'(1);
      end
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      state_q    <= ST_INIT;
      post_cnt_q <= '0;
      out_cnt_q  <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      // NOTE: the delay line is a small register array that must read as zero after reset, so it is cleared.
      for (int i = 0; i < PRE_ACQ_LEN; i++) dl_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
      out_cnt_q  <= out_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      for (int i = 0; i < PRE_ACQ_LEN; i++) dl_q[i] <= dl_d[i];
    end
  end

  assign EXEC_STATE    = state_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed bench for trigger_ctrl: each beat carries a 32-bit tag in the lane nibbles above the samples.
module tb_trigger_ctrl;

  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic [11:0]   base;
  logic          calc;
  logic [1:0]    st;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_last;

  int checks  = 0;
  int errors  = 0;
  int t       = 1;
  int gap_err = 0;
  int q_tag[$];
  bit q_last[$];

  always #5 clk = ~clk;

  trigger_ctrl dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESET    (rst),
    .S_AXIS_TDATA   (s_data),
    .S_AXIS_TVALID  (s_valid),
    .I_BASELINE     (base),
    .I_CALC_COMPLETE(calc),
    .EXEC_STATE     (st),
    .M_AXIS_TDATA   (m_data),
    .M_AXIS_TVALID  (m_valid),
    .M_AXIS_TLAST   (m_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int get_tag(input logic [W-1:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = d[16*k+12 +: 4];
    return int'(r);
  endfunction

  // One clock: drive a beat (all lanes s, lane hl replaced by hv), then sample 1ns after the edge.
  task automatic drive(input bit v, input logic [11:0] s, input int hl, input logic [11:0] hv);
    logic [31:0] tg;
    tg = t;
    for (int k = 0; k < 8; k++) s_data[16*k +: 16] = {tg[4*k +: 4], (k == hl) ? hv : s};
    s_valid = v;
    if (v) t++;
    @(posedge clk);
    #1;
    if (m_valid) begin
      q_tag.push_back(get_tag(m_data));
      q_last.push_back(m_last);
    end
    if (!v && (m_valid || m_last)) gap_err++;
  endtask

  task automatic plain(input int n);
    repeat (n) drive(1'b1, 12'd509, -1, 12'd0);
  endtask

  task automatic fire();
    drive(1'b1, 12'd509, 3, 12'd510);
  endtask

  task automatic clear_q();
    q_tag.delete();
    q_last.delete();
  endtask

  task automatic win_check(input string nm, input int n, input int first);
    int bad;
    int lasts;
    bad   = 0;
    lasts = 0;
    check({nm, "_count"}, q_tag.size(), n);
    for (int i = 0; i < q_tag.size(); i++) begin
      if (q_tag[i] != first + i) bad++;
      if (q_last[i]) lasts++;
    end
    check({nm, "_order_errs"}, bad, 0);
    check({nm, "_tlast_count"}, lasts, 1);
    if (q_tag.size() > 0) begin
      check({nm, "_first_tag"}, q_tag[0], first);
      check({nm, "_last_tag"}, q_tag[q_tag.size()-1], first + n - 1);
      check({nm, "_tlast_on_final"}, q_last[q_last.size()-1], 1);
    end
  endtask

  initial begin
    int tt;
    int lasts;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    base    = 12'd100;
    calc    = 1'b0;

    // Reset state, including a hitting beat presented during reset
    drive(1'b0, 12'd0, -1, 12'd0);
    drive(1'b1, 12'd600, -1, 12'd0);
    drive(1'b0, 12'd0, -1, 12'd0);
    check("rst_state", st, 2'b00);
    check("rst_tvalid", m_valid, 0);
    check("rst_tlast", m_last, 0);
    check("rst_tdata", m_data, 0);

    // Hits in INIT are ignored; baseline-valid moves to IDLE
    rst = 1'b0;
    drive(1'b1, 12'd600, -1, 12'd0);
    check("init_ignores_hit", st, 2'b00);
    plain(4);
    calc = 1'b1;
    plain(1);
    check("init_to_idle", st, 2'b01);

    // 509 - 100 = 409 is not above threshold
    clear_q();
    plain(30);
    check("at_threshold_state", st, 2'b01);
    check("at_threshold_no_out", q_tag.size(), 0);

    // Single trigger: 410 > 409
    clear_q();
    tt = t;
    fire();
    check("trg_next_clock", st, 2'b11);
    plain(30);
    win_check("single", 20, tt - 4);
    check("single_back_idle", st, 2'b01);

    // Most negative sample against negative baseline: no wrap-induced trigger
    base = 12'hFCE;
    clear_q();
    repeat (10) drive(1'b1, 12'h800, -1, 12'd0);
    check("neg_no_hit_state", st, 2'b01);
    check("neg_no_hit_out", q_tag.size(), 0);

    // Largest positive difference (2047 - -2048) must trigger
    base = 12'h800;
    clear_q();
    tt = t;
    drive(1'b1, 12'h800, 0, 12'h7FF);
    check("pos_extreme_trg", st, 2'b11);
    repeat (25) drive(1'b1, 12'h800, -1, 12'd0);
    win_check("pos_extreme", 20, tt - 4);

    // Second hit 5 beats after the first
    base = 12'd100;
    plain(5);
    clear_q();
    tt = t;
    fire();
    plain(4);
    fire();
    plain(35);
`ifdef TRIGGER_CTRL_RETRIGGER_EN
    win_check("retrig", 25, tt - 4);
`else
    win_check("retrig", 20, tt - 4);
`endif

    // Hit in IDLE during the pre-length tail extends one continuous window
    plain(5);
    clear_q();
    tt = t;
    fire();
    plain(16);
    check("tail_state_idle", st, 2'b01);
    fire();
    plain(45);
    win_check("tail", 37, tt - 4);

    // TVALID gapped 1-in-3
    plain(5);
    clear_q();
    gap_err = 0;
    tt = t;
    fire();
    repeat (60) begin
      drive(1'b0, 12'd509, -1, 12'd0);
      drive(1'b0, 12'd509, -1, 12'd0);
      drive(1'b1, 12'd509, -1, 12'd0);
    end
    win_check("gapped", 20, tt - 4);
    check("gapped_idle_outputs", gap_err, 0);

    // Reset pulsed after the 7th window beat
    plain(5);
    clear_q();
    fire();
    plain(6);
    check("abort_pre_count", q_tag.size(), 7);
    rst = 1'b1;
    drive(1'b0, 12'd509, -1, 12'd0);
    check("abort_tvalid", m_valid, 0);
    check("abort_tlast", m_last, 0);
    check("abort_tdata", m_data, 0);
    check("abort_state", st, 2'b00);
    rst = 1'b0;
    plain(30);
    lasts = 0;
    for (int i = 0; i < q_last.size(); i++) if (q_last[i]) lasts++;
    check("abort_post_count", q_tag.size(), 7);
    check("abort_no_tlast", lasts, 0);
    check("abort_restart_idle", st, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
